// File: rtl/wbram_reader_if.sv
// Weight beat stream from the BRAM reader to the MAC array.
// A beat transfers on any cycle with wt_valid && wt_ready; while wt_valid && !wt_ready the source holds every wt_* field stable.
interface wbram_reader_if #(
  parameter int WBRAM_WIDTH = 128,
  parameter int NUM_BANKS   = 16
);
  logic [NUM_BANKS*WBRAM_WIDTH-1:0] wt_data;
  logic [NUM_BANKS-1:0]             wt_mask;
  logic                             wt_last_acc;
  logic                             wt_last;
  logic                             wt_valid;
  logic                             wt_ready;

  modport master (
    output wt_data, wt_mask, wt_last_acc, wt_last, wt_valid,
    input  wt_ready
  );

  modport slave (
    input  wt_data, wt_mask, wt_last_acc, wt_last, wt_valid,
    output wt_ready
  );
endinterface

// File: rtl/wbram_reader.sv
// Read-side controller of the double-buffered weight BRAM: replays one published
// half-buffer per layer into a 2-entry output FIFO, then hands the half back to the writer.
module wbram_reader #(
  parameter int WBRAM_WIDTH     = 128,
  parameter int NUM_BANKS       = 16,
  parameter int WBRAM_DEPTH     = 128,
  parameter int MAX_IN_CHANNEL  = 45,
  parameter int MAX_KERNEL_SIZE = 5,
  parameter int MAX_OUT_CHANNEL = 128,
  parameter int MAX_OUT_SEQ     = 160,
  localparam int AW  = $clog2(WBRAM_DEPTH),
  localparam int ACW = $clog2(MAX_IN_CHANNEL*MAX_KERNEL_SIZE),
  localparam int OCW = $clog2(MAX_OUT_CHANNEL+1),
  localparam int SQW = $clog2(MAX_OUT_SEQ+1),
  localparam int LB  = $clog2(NUM_BANKS),
  localparam int DW  = NUM_BANKS*WBRAM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           i_wr_pointer_data,
  input  logic                 i_wr_pointer_valid,
  output logic                 o_wr_pointer_ready,
  output logic [1:0]           o_rd_pointer_data,
  output logic                 o_rd_pointer_valid,
  input  logic                 i_rd_pointer_ready,
  input  logic [ACW-1:0]       i_cfg_accum_total,
  input  logic [OCW-1:0]       i_cfg_out_channels,
  input  logic [SQW-1:0]       i_cfg_out_seq,
  input  logic                 i_cfg_valid,
  output logic                 o_cfg_ready,
  output logic [AW-1:0]        o_addrB,
  output logic [NUM_BANKS-1:0] o_enB,
  output logic                 o_ping_pong_rd,
  input  logic [DW-1:0]        i_doB,
  wbram_reader_if.master       wt,
  output logic [2:0]           o_dbg_state
);
  localparam int FW = DW + NUM_BANKS + 2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_BUF = 3'd1,
    S_READ     = 3'd2,
    S_DRAIN    = 3'd3,
    S_RELEASE  = 3'd4
  } state_t;

  state_t r_state, w_next_state;

  logic                 r_alive;
  logic [1:0]           r_wr_ptr, r_rd_ptr;
  logic [ACW-1:0]       r_accum;
  logic [OCW-1:0]       r_glast;
  logic [NUM_BANKS-1:0] r_last_mask;
  logic [SQW-1:0]       r_seq;
  logic [ACW-1:0]       r_k;
  logic [OCW-1:0]       r_g;
  logic [SQW-1:0]       r_p;
  logic [AW-1:0]        r_base;
  logic                 r_inflight, r_pipe_last_acc, r_pipe_last;
  logic [NUM_BANKS-1:0] r_pipe_mask;
  logic [FW-1:0]        r_mem [2];
  logic                 r_wr_idx, r_rd_idx;
  logic [1:0]           r_occ;

  logic                 w_empty, w_pop, w_room, w_fifo_valid, w_cfg_hs;
  logic                 w_cfg_ready, w_rd_valid, w_issue, w_drain_done;
  logic                 w_last_k, w_last_g, w_last_p, w_last_beat;
  logic [OCW-1:0]       w_glast;
  logic [LB-1:0]        w_rem;
  logic [NUM_BANKS-1:0] w_one_hot, w_last_mask;
  logic [FW-1:0]        w_head;

  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_valid = (r_occ != 2'd0);
  assign w_pop        = w_fifo_valid && wt.wt_ready;
  // Credit check: buffered beats plus the read in flight, net of this cycle's pop, must leave a free slot.
  assign w_room       = ({1'b0, r_occ} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop});
  assign w_cfg_hs     = w_cfg_ready && i_cfg_valid;

  assign w_last_k     = (r_k == r_accum - ACW'(1));
  assign w_last_g     = (r_g == r_glast);
  assign w_last_p     = (r_p == r_seq - SQW'(1));
  assign w_last_beat  = w_last_k && w_last_g && w_last_p;

  // Last group holds out_channels mod NUM_BANKS real lanes; a zero remainder means a full group.
  assign w_glast      = (i_cfg_out_channels - OCW'(1)) >> LB;
  assign w_rem        = i_cfg_out_channels[LB-1:0];
  assign w_one_hot    = {{(NUM_BANKS-1){1'b0}}, 1'b1} << w_rem;
  assign w_last_mask  = (w_rem == '0) ? '1 : (w_one_hot - NUM_BANKS'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (w_cfg_hs)                w_next_state = S_WAIT_BUF;
      S_WAIT_BUF: if (!w_empty)                w_next_state = S_READ;
      S_READ:     if (w_issue && w_last_beat)  w_next_state = S_DRAIN;
      S_DRAIN:    if (w_drain_done)            w_next_state = S_RELEASE;
      S_RELEASE:  if (i_rd_pointer_ready)      w_next_state = S_IDLE;
      default:                                 w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_cfg_ready  = 1'b0;
    w_rd_valid   = 1'b0;
    w_issue      = 1'b0;
    w_drain_done = 1'b0;
    case (r_state)
      S_IDLE:    w_cfg_ready  = r_alive;
      S_READ:    w_issue      = w_room;
      S_DRAIN:   w_drain_done = (r_occ == 2'd0) && !r_inflight;
      S_RELEASE: w_rd_valid   = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alive         <= 1'b0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_accum         <= '0;
      r_glast         <= '0;
      r_last_mask     <= '0;
      r_seq           <= '0;
      r_k             <= '0;
      r_g             <= '0;
      r_p             <= '0;
      r_base          <= '0;
      r_inflight      <= 1'b0;
      r_pipe_mask     <= '0;
      r_pipe_last_acc <= 1'b0;
      r_pipe_last     <= 1'b0;
      r_wr_idx        <= 1'b0;
      r_rd_idx        <= 1'b0;
      r_occ           <= '0;
    end else begin
      r_alive <= 1'b1;
      if (i_wr_pointer_valid && r_alive) r_wr_ptr <= i_wr_pointer_data;
      if (w_drain_done)                  r_rd_ptr <= r_rd_ptr + 2'd1;
      if (w_cfg_hs) begin
        r_accum     <= i_cfg_accum_total;
        r_glast     <= w_glast;
        r_last_mask <= w_last_mask;
        r_seq       <= i_cfg_out_seq;
      end
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pipe_mask     <= w_last_g ? r_last_mask : '1;
        r_pipe_last_acc <= w_last_k;
        r_pipe_last     <= w_last_beat;
        // Group base advances by accumulation so the address never needs a multiply.
        if (w_last_k) begin
          r_k <= '0;
          if (w_last_g) begin
            r_g    <= '0;
            r_base <= '0;
            r_p    <= w_last_p ? '0 : r_p + SQW'(1);
          end else begin
            r_g    <= r_g + OCW'(1);
            r_base <= r_base + r_accum[AW-1:0];
          end
        end else begin
          r_k <= r_k + ACW'(1);
        end
      end
      if (r_inflight) r_wr_idx <= ~r_wr_idx;
      if (w_pop)      r_rd_idx <= ~r_rd_idx;
      r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (r_inflight) r_mem[r_wr_idx] <= {i_doB, r_pipe_mask, r_pipe_last_acc, r_pipe_last};
  end

  assign w_head         = r_mem[r_rd_idx];
  assign wt.wt_valid    = w_fifo_valid;
  assign wt.wt_data     = w_fifo_valid ? w_head[FW-1 -: DW] : '0;
  assign wt.wt_mask     = w_fifo_valid ? w_head[NUM_BANKS+1:2] : '0;
  assign wt.wt_last_acc = w_fifo_valid && w_head[1];
  assign wt.wt_last     = w_fifo_valid && w_head[0];

  assign o_wr_pointer_ready = r_alive;
  assign o_rd_pointer_data  = r_rd_ptr;
  assign o_rd_pointer_valid = w_rd_valid;
  assign o_cfg_ready        = w_cfg_ready;
  assign o_addrB            = r_base + r_k[AW-1:0];
  assign o_enB              = {NUM_BANKS{w_issue}};
  assign o_ping_pong_rd     = r_rd_ptr[0];
  assign o_dbg_state        = r_state;
endmodule

// File: tb/tb_wbram_reader.sv
// Scoreboard bench for wbram_reader: a BRAM model answers reads, expected beats and
// addresses are queued per layer and popped as the DUT reads and emits.
module tb_wbram_reader;
  localparam int W = 128, NB = 16, DW = NB*W, BW = DW + NB + 2;
  localparam int AW = 7, ACW = 8, OCW = 8, SQW = 8;

  logic           clk = 1'b0, rst_n = 1'b0;
  logic [1:0]     wr_data = '0;
  logic           wr_valid = 1'b0, rd_ready = 1'b0, cfg_valid = 1'b0;
  logic [ACW-1:0] cfg_accum = '0;
  logic [OCW-1:0] cfg_ch = '0;
  logic [SQW-1:0] cfg_seq = '0;
  logic [DW-1:0]  doB = '0;
  wire            wr_ready, rd_valid, cfg_ready, pp;
  wire [1:0]      rd_data;
  wire [AW-1:0]   addrB;
  wire [NB-1:0]   enB;
  wire [2:0]      dbg_state;

  wbram_reader_if #(.WBRAM_WIDTH(W), .NUM_BANKS(NB)) wt_if ();

  wbram_reader dut (
    .clk(clk), .rst_n(rst_n),
    .i_wr_pointer_data(wr_data), .i_wr_pointer_valid(wr_valid), .o_wr_pointer_ready(wr_ready),
    .o_rd_pointer_data(rd_data), .o_rd_pointer_valid(rd_valid), .i_rd_pointer_ready(rd_ready),
    .i_cfg_accum_total(cfg_accum), .i_cfg_out_channels(cfg_ch), .i_cfg_out_seq(cfg_seq),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
    .o_addrB(addrB), .o_enB(enB), .o_ping_pong_rd(pp), .i_doB(doB),
    .wt(wt_if.master), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [BW-1:0] exp_q[$];
  logic [AW:0]   exp_addr_q[$];
  int n_vec = 0, n_err = 0, cyc = 0, issued = 0, popped = 0;
  int first_en = -1, first_pop = -1, last_pop = -1;
  int tb_wr_ptr = 0, tb_rd_ptr = 0, rdy_mode = 0;
  bit mon_en = 1'b0, stalled = 1'b0;
  logic [BW-1:0] held, cur, ex;
  logic [AW:0]   ea;
  bit            pop_now;
  bit            pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  function automatic logic [DW-1:0] make_data(input int p, input int a);
    logic [DW-1:0] d;
    for (int b = 0; b < NB; b++) d[b*W +: W] = {4{8'(p), 8'(a), 8'(b), 8'hA5}};
    return d;
  endfunction

  function automatic logic [BW-1:0] make_beat(input int p, input int a, input logic [NB-1:0] m,
                                              input bit la, input bit l);
    return {make_data(p, a), m, la, l};
  endfunction

  // Bank model with one-cycle read latency.
  always @(posedge clk) if (|enB) doB <= make_data(int'(pp), int'(addrB));

  initial begin
    int pi;
    pi = 0;
    wt_if.wt_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       begin wt_if.wt_ready = pat[pi % 6]; pi++; end
        2:       wt_if.wt_ready = ($urandom_range(0, 3) != 0);
        default: wt_if.wt_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      pop_now = wt_if.wt_valid && wt_if.wt_ready;
      cur = {wt_if.wt_data, wt_if.wt_mask, wt_if.wt_last_acc, wt_if.wt_last};
      if (|enB) begin
        n_vec++;
        if (enB !== {NB{1'b1}}) begin n_err++; $display("FAIL enb_all_banks: got %h want ffff", enB); end
        n_vec++;
        if (exp_addr_q.size() == 0) begin
          n_err++; $display("FAIL extra_read: got read of addr %0d want no read", addrB);
        end else begin
          ea = exp_addr_q.pop_front();
          if ({pp, addrB} !== ea) begin
            n_err++; $display("FAIL read_addr: got pp=%0d addr=%0d want pp=%0d addr=%0d", pp, addrB, ea[AW], ea[AW-1:0]);
          end
        end
        n_vec++;
        if (issued - popped - int'(pop_now) >= 2) begin
          n_err++; $display("FAIL fifo_credit: got %0d outstanding want < 2", issued - popped - int'(pop_now));
        end
        n_vec++;
        if (tb_wr_ptr == tb_rd_ptr) begin n_err++; $display("FAIL read_while_empty: got enB with wr=rd=%0d want none", tb_wr_ptr); end
        if (first_en < 0) first_en = cyc;
        issued++;
      end
      if (stalled) begin
        n_vec++;
        if (!wt_if.wt_valid || cur !== held) begin
          n_err++; $display("FAIL hold_while_stalled: got valid=%b mask=%h last=%b want valid=1 mask=%h last=%b", wt_if.wt_valid, cur[NB+1:2], cur[0], held[NB+1:2], held[0]);
        end
      end
      if (pop_now) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL extra_beat: got beat mask=%h want no beat", cur[NB+1:2]);
        end else begin
          ex = exp_q.pop_front();
          if (cur !== ex) begin
            n_err++; $display("FAIL beat: got mask=%h la=%b last=%b d=%h want mask=%h la=%b last=%b d=%h", cur[NB+1:2], cur[1], cur[0], cur[BW-1 -: 32], ex[NB+1:2], ex[1], ex[0], ex[BW-1 -: 32]);
          end
        end
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        popped++;
      end
      stalled = wt_if.wt_valid && !wt_if.wt_ready;
      held = cur;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_wr(input int v);
    wr_data = v[1:0]; wr_valid = 1'b1;
    @(posedge clk);
    tb_wr_ptr = v;
    #1 wr_valid = 1'b0;
  endtask

  task automatic send_cfg(input int accum, input int ch, input int seq);
    int t;
    cfg_accum = ACW'(accum); cfg_ch = OCW'(ch); cfg_seq = SQW'(seq); cfg_valid = 1'b1;
    t = 0;
    while (!cfg_ready && t < 200) begin tick(); t++; end
    n_vec++;
    if (!cfg_ready) begin n_err++; $display("FAIL cfg_timeout: got cfg_ready=0 want 1 within 200 cycles"); end
    @(posedge clk); #1 cfg_valid = 1'b0;
  endtask

  task automatic run_layer(input string name, input int accum, input int ch, input int seq,
                           input int wr_new, input bit cfg_first, input int wr_at_release,
                           input bit check_timing);
    int groups, ppv, nb, start_pop, t, exp_rd, m;
    logic [AW:0] av;
    groups = (ch + 15) / 16;
    ppv = tb_rd_ptr % 2;
    nb = 0;
    for (int p = 0; p < seq; p++)
      for (int g = 0; g < groups; g++)
        for (int k = 0; k < accum; k++) begin
          int a;
          a = g*accum + k;
          m = (g == groups-1) ? ((1 << (ch - 16*g)) - 1) : 32'hFFFF;
          av = {1'(ppv), 7'(a)};
          exp_addr_q.push_back(av);
          exp_q.push_back(make_beat(ppv, a, m[NB-1:0], k == accum-1,
                                    (p == seq-1) && (g == groups-1) && (k == accum-1)));
          nb++;
        end
    first_en = -1; first_pop = -1; last_pop = -1;
    start_pop = popped;
    if (!cfg_first && wr_new >= 0) send_wr(wr_new);
    send_cfg(accum, ch, seq);
    if (cfg_first) begin
      repeat (4) tick();
      n_vec++;
      if (dbg_state !== 3'd1) begin n_err++; $display("FAIL %s wait_buf: got state %0d want 1", name, dbg_state); end
      send_wr(wr_new);
    end
    t = 0;
    while (!rd_valid && t < 3000) begin tick(); t++; end
    exp_rd = (tb_rd_ptr + 1) % 4;
    n_vec++;
    if (!rd_valid) begin
      n_err++; $display("FAIL %s release_timeout: got rd_pointer_valid=0 want 1 within 3000 cycles", name);
    end else begin
      n_vec++;
      if (rd_data !== 2'(exp_rd)) begin n_err++; $display("FAIL %s rd_pointer: got %0d want %0d", name, rd_data, exp_rd); end
      tick(); tick();
      n_vec++;
      if (!rd_valid || rd_data !== 2'(exp_rd)) begin
        n_err++; $display("FAIL %s rd_pointer_hold: got valid=%b data=%0d want valid=1 data=%0d", name, rd_valid, rd_data, exp_rd);
      end
      rd_ready = 1'b1;
      if (wr_at_release >= 0) begin wr_data = wr_at_release[1:0]; wr_valid = 1'b1; end
      @(posedge clk);
      tb_rd_ptr = exp_rd;
      if (wr_at_release >= 0) tb_wr_ptr = wr_at_release;
      #1 rd_ready = 1'b0; wr_valid = 1'b0;
      n_vec++;
      if (rd_valid !== 1'b0 || dbg_state !== 3'd0) begin
        n_err++; $display("FAIL %s back_to_idle: got valid=%b state=%0d want valid=0 state=0", name, rd_valid, dbg_state);
      end
    end
    n_vec++;
    if (popped - start_pop != nb || exp_q.size() != 0 || exp_addr_q.size() != 0) begin
      n_err++; $display("FAIL %s beat_count: got %0d beats (%0d reads left) want %0d", name, popped - start_pop, exp_addr_q.size(), nb);
      exp_q.delete(); exp_addr_q.delete();
    end
    if (check_timing) begin
      n_vec++;
      if (first_pop - first_en < 2) begin n_err++; $display("FAIL %s read_latency: got %0d want >= 2", name, first_pop - first_en); end
      n_vec++;
      if (last_pop - first_pop != nb - 1) begin n_err++; $display("FAIL %s throughput: got span %0d want %0d", name, last_pop - first_pop, nb - 1); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_vec++;
    if ({wr_ready, rd_valid, rd_data, cfg_ready, enB, addrB, pp} !== '0) begin
      n_err++; $display("FAIL reset_ctrl: got wr_rdy=%b rd_v=%b rd=%0d cfg_rdy=%b en=%h addr=%0d pp=%b want all 0", wr_ready, rd_valid, rd_data, cfg_ready, enB, addrB, pp);
    end
    n_vec++;
    if ({wt_if.wt_valid, wt_if.wt_mask, wt_if.wt_last, wt_if.wt_last_acc} !== '0 || wt_if.wt_data !== '0 || dbg_state !== 3'd0) begin
      n_err++; $display("FAIL reset_wt: got valid=%b mask=%h last=%b la=%b state=%0d want all 0", wt_if.wt_valid, wt_if.wt_mask, wt_if.wt_last, wt_if.wt_last_acc, dbg_state);
    end
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (wr_ready !== 1'b1 || cfg_ready !== 1'b1) begin
      n_err++; $display("FAIL after_reset: got wr_rdy=%b cfg_rdy=%b want 1 1", wr_ready, cfg_ready);
    end
  endtask

  task automatic test_basic();           rdy_mode = 0; run_layer("basic",   3, 16, 1, 1, 1'b0, -1, 1'b1); endtask
  task automatic test_partial_group();   rdy_mode = 0; run_layer("partial", 2, 20, 1, 2, 1'b0, -1, 1'b1); endtask
  task automatic test_replay();          rdy_mode = 0; run_layer("replay",  2, 16, 3, 3, 1'b0, -1, 1'b1); endtask
  task automatic test_backpressure();    rdy_mode = 1; run_layer("backpr",  2, 16, 3, 0, 1'b0, -1, 1'b0); endtask

  task automatic test_ping_pong_wrap();
    rdy_mode = 2;
    for (int i = 0; i < 4; i++) begin
      int a, c, s;
      a = (i == 3) ? 3 : int'($urandom_range(1, 4));
      c = (i == 3) ? 128 : int'($urandom_range(1, 40));
      s = (i == 3) ? 2 : int'($urandom_range(1, 2));
      run_layer("wrap", a, c, s, (i == 0) ? 1 : -1, i == 0, (i < 3) ? (i + 2) % 4 : -1, 1'b0);
    end
    rdy_mode = 0;
  endtask

  task automatic test_reset_mid_read();
    int cnt, t, viol;
    mon_en = 1'b0;
    rdy_mode = 0;
    send_wr(1);
    send_cfg(2, 16, 3);
    cnt = 0; t = 0;
    while (cnt < 2 && t < 100) begin if (wt_if.wt_valid) cnt++; tick(); t++; end
    n_vec++;
    if (cnt < 2) begin n_err++; $display("FAIL midread_start: got %0d beats want 2", cnt); end
    rst_n = 1'b0;
    tick();
    n_vec++;
    if ({wr_ready, rd_valid, rd_data, cfg_ready, enB, addrB, pp, wt_if.wt_valid, wt_if.wt_mask,
         wt_if.wt_last, wt_if.wt_last_acc} !== '0 || wt_if.wt_data !== '0 || dbg_state !== 3'd0) begin
      n_err++; $display("FAIL midread_reset: got wr_rdy=%b cfg_rdy=%b en=%h addr=%0d valid=%b state=%0d want all 0", wr_ready, cfg_ready, enB, addrB, wt_if.wt_valid, dbg_state);
    end
    rst_n = 1'b1;
    viol = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (rd_valid || (|enB) || wt_if.wt_valid) viol++; end
    n_vec++;
    if (viol != 0 || cfg_ready !== 1'b1) begin
      n_err++; $display("FAIL midread_quiet: got %0d active cycles cfg_rdy=%b want 0 and 1", viol, cfg_ready);
    end
    tb_wr_ptr = 0; tb_rd_ptr = 0;
    exp_q.delete(); exp_addr_q.delete();
    issued = 0; popped = 0; stalled = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_recover(); rdy_mode = 0; run_layer("recover", 3, 16, 1, 1, 1'b0, -1, 1'b1); endtask

  initial begin
    test_reset();
    mon_en = 1'b1;
    test_basic();
    test_partial_group();
    test_replay();
    test_backpressure();
    test_ping_pong_wrap();
    test_reset_mid_read();
    test_recover();
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #600000;
    n_err++;
    $display("FAIL watchdog: got no finish want finish before 600000 time units");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wbram_reader.md
# wbram_reader

Read-side controller for the double-buffered, 16-bank weight BRAM. It sits downstream of the weight-write controller and upstream of the MAC array. Once the writer publishes a filled half-buffer, the block reads that half's layer weights from all banks in parallel, 16 output channels per beat. It replays the weights once per output-sequence position and streams them out with valid/ready. It then returns the buffer to the writer by advancing the read pointer.

## Interface
- WBRAM_WIDTH, 128: bits per bank word
- NUM_BANKS, 16: banks, one output channel per bank per beat
- WBRAM_DEPTH, 128: words per bank per ping-pong half
- MAX_IN_CHANNEL, 45; MAX_KERNEL_SIZE, 5; MAX_OUT_CHANNEL, 128; MAX_OUT_SEQ, 160
- AW = $clog2(WBRAM_DEPTH); ACW = $clog2(MAX_IN_CHANNEL*MAX_KERNEL_SIZE); OCW = $clog2(MAX_OUT_CHANNEL+1); SQW = $clog2(MAX_OUT_SEQ+1)

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, synchronous, active-low
- wr_pointer_data  in  2  writer pointer (bit1 wrap, bit0 half)
- wr_pointer_valid  in  1
- wr_pointer_ready  out  1
- rd_pointer_data  out  2  reader pointer returned to writer
- rd_pointer_valid  out  1
- rd_pointer_ready  in  1
- cfg_accum_total  in  ACW  words per output channel, 1..225
- cfg_out_channels  in  OCW  output channels in layer, 1..128
- cfg_out_seq  in  SQW  weight replays, 1..160
- cfg_valid  in  1; cfg_ready  out  1
- addrB  out  AW  read address, broadcast to all banks
- enB  out  NUM_BANKS  read enable, all bits equal
- ping_pong_rd  out  1  half select, = rd pointer bit0
- doB  in  NUM_BANKS*WBRAM_WIDTH  bank read data, 1-cycle latency
- wt_data  out  NUM_BANKS*WBRAM_WIDTH
- wt_mask  out  NUM_BANKS  lanes holding a real channel
- wt_last_acc  out  1  last word of one channel's accumulation
- wt_last  out  1  final beat of the layer
- wt_valid  out  1; wt_ready  in  1

## Operation
- Pointers: wr_ptr_q is loaded on every wr_pointer handshake; wr_pointer_ready = 1 whenever not in reset. rd_ptr_q is the 2-bit wrap counter. empty = (wr_ptr_q == rd_ptr_q).
- Layout: bank b holds channels b, b+16, … Group g occupies words g*accum_total .. g*accum_total+accum_total-1. Group count G = ceil(out_channels/16).
- Loop order: pass p (0..out_seq-1) outer, group g middle, word k inner. addrB = base + k, where base += accum_total at each group end and base returns to 0 at each pass end. No multiplier.
- wt_mask is all ones, except on group G-1: (1<<(out_channels-16*(G-1)))-1.
- wt_last_acc is set when k = accum_total-1. wt_last is set when p, g and k are all at their last values.
- FSM:
  - IDLE: cfg_ready=1. On cfg handshake, latch the config and go to WAIT_BUF.
  - WAIT_BUF: go to READ when !empty.
  - READ: issue a read when occ + inflight - pop < 2. occ is output FIFO occupancy, inflight is the read issued last cycle, pop = wt_valid&wt_ready. After issuing the last read, go to DRAIN.
  - DRAIN: when the FIFO is empty and nothing is in flight, rd_ptr_q += 1 and go to RELEASE.
  - RELEASE: rd_pointer_valid=1 holding rd_ptr_q. On rd_pointer_ready, go to IDLE.
- Output FIFO: 2 entries, capturing doB plus sideband. The FIFO is never overrun and no beat is dropped or duplicated.
- Config inputs are ignored outside IDLE.

## Timing
- Reset values: rd_ptr_q=0, wr_ptr_q=0, state=IDLE, FIFO empty.
- Output reset values: wr_pointer_ready=0, rd_pointer_valid=0, rd_pointer_data=0, cfg_ready=0, enB=0, addrB=0, ping_pong_rd=0, wt_valid=0, wt_data=0, wt_mask=0, wt_last=0, wt_last_acc=0.
- Cycle after reset release: wr_pointer_ready=1, cfg_ready=1.
- Read pipeline: enB is high in cycle t. doB is valid in t+1 and written to the FIFO at the end of t+1. wt_valid is high at t+2 at the earliest.
- Sustained throughput is 1 beat/cycle with wt_ready held at 1.
- wt_* stay stable while wt_valid && !wt_ready. rd_pointer_data stays stable while rd_pointer_valid && !rd_pointer_ready.
- A wr_pointer update in the same cycle as the RELEASE handshake: both take effect, and empty is re-evaluated the next cycle.
- cfg arriving while the buffer is still empty is legal; the block waits in WAIT_BUF.
- Reset asserted in any state: all state returns to the reset values at the next edge. In-flight data is discarded and no rd_pointer is sent.
- Pointer wrap: 3 → 0.

## Test plan
- Basic: cfg accum=3, ch=16, seq=1; wr_pointer=1 → addrB 0,1,2; ping_pong_rd=0; 3 beats with mask 0xFFFF; wt_last and wt_last_acc on beat 3; then rd_pointer_data=1 valid.
- Partial group: accum=2, ch=20, seq=1 → addrB 0,1,2,3; masks FFFF,FFFF,000F,000F; wt_last_acc on beats 2 and 4.
- Replay: accum=2, ch=16, seq=3 → addrB 0,1,0,1,0,1; wt_last only on beat 6.
- Backpressure: same as Replay with wt_ready pattern 1,0,0,1,0,1… → 6 beats, correct order, enB never issued with occ+inflight-pop ≥ 2, outputs stable while stalled.
- Ping-pong wrap: four layers with wr_pointer 1,2,3,0 → ping_pong_rd 0,1,0,1; rd_pointer_data 1,2,3,0; no enB while wr==rd.
- Reset mid-READ: rst_n low for 1 cycle at beat 2 → all outputs at reset values, FSM in IDLE, rd_pointer never asserted.
